// File: rtl/serial_pkg.sv
// serial_pkg: shared types and constants for the serial_tx frame transmitter.
//   state_t        : transmitter FSM states (PARITY is used only when
//                    SERIAL_TX_PARITY_EN is defined)
//   cnt_width()    : bit-counter width for a given payload width
//   IDLE_LEVEL_DEF : default level of sdata between frames
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam logic IDLE_LEVEL_DEF = 1'b0;

  // The counter holds the index of the bit currently on sdata (0..w-1), so
  // clog2(w) bits are enough; keep at least one bit for the w=1 corner.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_tx_if.sv
// serial_tx_if: load handshake and serial-side signals of serial_tx.
//   din        : parallel payload, sampled on the accepting edge
//   load_valid : producer offers din
//   load_ready : transmitter can accept a word
//   sdata      : registered serial data
//   sframe     : high while payload (and parity) bits are on sdata
//   done       : one-cycle pulse after the last bit of a frame
// Modports: master = producer / monitor side, slave = transmitter side.
interface serial_tx_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             load_valid;
  logic             load_ready;
  logic             sdata;
  logic             sframe;
  logic             done;

  modport master (
    output din, load_valid,
    input  load_ready, sdata, sframe, done
  );

  modport slave (
    input  din, load_valid,
    output load_ready, sdata, sframe, done
  );
endinterface

// File: rtl/rising_edge_dff.sv
// rising_edge_dff: WIDTH-bit rising-edge register with asynchronous
// active-high reset to RST_VAL and a load enable. Launch-side partner of the
// falling-edge capture flops on the receiving end of the serial link.
//   clk : clock        rst : async reset, active-high
//   en  : load enable  d   : next value   q : registered value
module rising_edge_dff #(
  parameter int unsigned       WIDTH   = 1,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/serial_tx.sv
// serial_tx: parallel-in / serial-out frame transmitter. A word is accepted
// through a valid/ready handshake, launched one bit per rising edge on sdata
// with sframe high, and completion is flagged by a one-cycle done pulse.
// sdata is registered so it is stable for a whole cycle, suiting a receiver
// that captures on the falling edge of clk.
// Ports:
//   clk : clock, all state changes on its rising edge
//   R   : asynchronous active-high reset (aborts a frame, no done)
//   tx  : serial_tx_if.slave (din, load_valid, load_ready, sdata, sframe, done)
// Parameters: WIDTH (2..32), MSB_FIRST, IDLE_LEVEL.
// Optional feature: define SERIAL_TX_PARITY_EN to append an even-parity bit
// (PARITY state) after the payload.
module serial_tx
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = IDLE_LEVEL_DEF
) (
  input  logic       clk,
  input  logic       R,
  serial_tx_if.slave tx
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_t state_q, state_d;

  logic [WIDTH-1:0] shift_q, shift_d;
  logic             shift_en;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sdata_q, sdata_d;
  logic             sframe_q, sframe_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;

  logic accept;
  logic last_bit;

`ifdef SERIAL_TX_PARITY_EN
  logic parity_q, parity_d;
`endif

  // Bit that leaves the word first, and the word with that bit consumed.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] consume(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign accept   = (state_q == IDLE) && tx.load_valid && ready_q;
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = SHIFT;
      end
      SHIFT: begin
`ifdef SERIAL_TX_PARITY_EN
        if (last_bit) state_d = PARITY;
`else
        if (last_bit) state_d = IDLE;
`endif
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath logic. Every output is the next value of a register,
  // so nothing on the interface depends combinationally on an input.
  always_comb begin
    shift_d  = shift_q;
    shift_en = 1'b0;
    cnt_d    = cnt_q;
    sdata_d  = sdata_q;
    sframe_d = sframe_q;
    done_d   = 1'b0;
    ready_d  = ready_q;
`ifdef SERIAL_TX_PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      IDLE: begin
        sdata_d  = IDLE_LEVEL;
        sframe_d = 1'b0;
        ready_d  = 1'b1;
        if (accept) begin
          // First bit goes out on the accepting edge; the shift register
          // keeps the remaining bits with the next one at its head.
          shift_d  = consume(tx.din);
          shift_en = 1'b1;
          cnt_d    = '0;
          sdata_d  = head_bit(tx.din);
          sframe_d = 1'b1;
          ready_d  = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
          parity_d = ^tx.din;
`endif
        end
      end
      SHIFT: begin
        if (last_bit) begin
`ifdef SERIAL_TX_PARITY_EN
          sdata_d  = parity_q;
          sframe_d = 1'b1;
`else
          sdata_d  = IDLE_LEVEL;
          sframe_d = 1'b0;
          done_d   = 1'b1;
          ready_d  = 1'b1;
`endif
        end else begin
          shift_d  = consume(shift_q);
          shift_en = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          sdata_d  = head_bit(shift_q);
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        sdata_d  = IDLE_LEVEL;
        sframe_d = 1'b0;
        done_d   = 1'b1;
        ready_d  = 1'b1;
      end
`endif
      default: begin
        sdata_d  = IDLE_LEVEL;
        sframe_d = 1'b0;
        ready_d  = 1'b1;
      end
    endcase
  end

  rising_edge_dff #(.WIDTH(WIDTH), .RST_VAL('0)) u_shift (
    .clk(clk), .rst(R), .en(shift_en), .d(shift_d), .q(shift_q)
  );

  rising_edge_dff #(.WIDTH(CNT_W), .RST_VAL('0)) u_cnt (
    .clk(clk), .rst(R), .en(1'b1), .d(cnt_d), .q(cnt_q)
  );

  rising_edge_dff #(.WIDTH(1), .RST_VAL(IDLE_LEVEL)) u_sdata (
    .clk(clk), .rst(R), .en(1'b1), .d(sdata_d), .q(sdata_q)
  );

  rising_edge_dff #(.WIDTH(1), .RST_VAL(1'b0)) u_sframe (
    .clk(clk), .rst(R), .en(1'b1), .d(sframe_d), .q(sframe_q)
  );

  rising_edge_dff #(.WIDTH(1), .RST_VAL(1'b0)) u_done (
    .clk(clk), .rst(R), .en(1'b1), .d(done_d), .q(done_q)
  );

  rising_edge_dff #(.WIDTH(1), .RST_VAL(1'b1)) u_ready (
    .clk(clk), .rst(R), .en(1'b1), .d(ready_d), .q(ready_q)
  );

`ifdef SERIAL_TX_PARITY_EN
  rising_edge_dff #(.WIDTH(1), .RST_VAL(1'b0)) u_parity (
    .clk(clk), .rst(R), .en(1'b1), .d(parity_d), .q(parity_q)
  );
`endif

  assign tx.sdata      = sdata_q;
  assign tx.sframe     = sframe_q;
  assign tx.done       = done_q;
  assign tx.load_ready = ready_q;

endmodule

// File: tb/tb_serial_tx.sv
module tb_serial_tx;

`ifdef SERIAL_TX_PARITY_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif

  logic clk;
  logic rst;

  int n_tests = 0;
  int n_fail  = 0;

  serial_tx_if #(.WIDTH(8)) m_if ();
  serial_tx_if #(.WIDTH(8)) l_if ();

  serial_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
    .clk(clk), .R(rst), .tx(m_if)
  );

  serial_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
    .clk(clk), .R(rst), .tx(l_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Falling-edge receiver model for the MSB-first instance.
  logic        cap_clr = 1'b1;
  logic [15:0] rx_word;
  int          rx_cnt;

  always @(negedge clk) begin
    if (cap_clr) begin
      rx_word <= '0;
      rx_cnt  <= 0;
    end else if (m_if.sframe) begin
      rx_word <= {rx_word[14:0], m_if.sdata};
      rx_cnt  <= rx_cnt + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends one word on the MSB-first instance. Entered one time unit after a
  // rising edge with the transmitter idle; returns in the done cycle.
  task automatic frame_msb(input logic [7:0] w, input logic [7:0] later,
                           input bit keep_valid, input string tag);
    logic [15:0] exp_rx;
    chk({tag, "_ready_pre"}, 16'(m_if.load_ready), 16'h1);
    m_if.din        = w;
    m_if.load_valid = 1'b1;
    cap_clr         = 1'b1;
    step();
    cap_clr = 1'b0;
    if (!keep_valid) m_if.load_valid = 1'b0;
    m_if.din = later;
    for (int k = 0; k < 8; k++) begin
      chk({tag, "_sdata"},  16'(m_if.sdata), 16'(w[7-k]));
      chk({tag, "_sframe"}, 16'(m_if.sframe), 16'h1);
      chk({tag, "_ready"},  16'(m_if.load_ready), 16'h0);
      chk({tag, "_done"},   16'(m_if.done), 16'h0);
      step();
    end
`ifdef SERIAL_TX_PARITY_EN
    chk({tag, "_parity"},     16'(m_if.sdata), 16'(^w));
    chk({tag, "_par_sframe"}, 16'(m_if.sframe), 16'h1);
    chk({tag, "_par_done"},   16'(m_if.done), 16'h0);
    step();
`endif
    chk({tag, "_end_sframe"}, 16'(m_if.sframe), 16'h0);
    chk({tag, "_end_done"},   16'(m_if.done), 16'h1);
    chk({tag, "_end_ready"},  16'(m_if.load_ready), 16'h1);
    chk({tag, "_end_sdata"},  16'(m_if.sdata), 16'h0);
    exp_rx = (NPAR != 0) ? {7'b0, w, ^w} : {8'b0, w};
    chk({tag, "_rx_word"}, rx_word, exp_rx);
    chk({tag, "_rx_cnt"},  16'(rx_cnt), 16'(8 + NPAR));
  endtask

  initial begin
    rst             = 1'b1;
    m_if.din        = 8'hFF;
    m_if.load_valid = 1'b1;
    l_if.din        = 8'h00;
    l_if.load_valid = 1'b0;

    // Reset held with a word offered: nothing may be accepted.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_ready",  16'(m_if.load_ready), 16'h1);
      chk("rst_sdata",  16'(m_if.sdata), 16'h0);
      chk("rst_sframe", 16'(m_if.sframe), 16'h0);
      chk("rst_done",   16'(m_if.done), 16'h0);
    end
    m_if.load_valid = 1'b0;
    rst = 1'b0;
    step();
    chk("post_rst_sframe", 16'(m_if.sframe), 16'h0);
    chk("post_rst_ready",  16'(m_if.load_ready), 16'h1);

    // Basic MSB-first frame; din changes after accept are ignored.
    frame_msb(8'hA5, 8'h5A, 1'b0, "a5");
    step();
    chk("a5_done_one_cycle", 16'(m_if.done), 16'h0);
    chk("a5_idle_sframe",    16'(m_if.sframe), 16'h0);

    // LSB-first: 8'h01 sends a single 1 first.
    l_if.din        = 8'h01;
    l_if.load_valid = 1'b1;
    step();
    l_if.load_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("lsb_sdata",  16'(l_if.sdata), (k == 0) ? 16'h1 : 16'h0);
      chk("lsb_sframe", 16'(l_if.sframe), 16'h1);
      step();
    end
`ifdef SERIAL_TX_PARITY_EN
    chk("lsb_parity", 16'(l_if.sdata), 16'h1);
    step();
`endif
    chk("lsb_done",       16'(l_if.done), 16'h1);
    chk("lsb_end_sframe", 16'(l_if.sframe), 16'h0);

    // Back-to-back with load_valid held: second accept right after done.
    step();
    frame_msb(8'h3C, 8'hC3, 1'b1, "b2b1");
    frame_msb(8'hC3, 8'h00, 1'b0, "b2b2");
    step();
    chk("b2b_done_clear", 16'(m_if.done), 16'h0);

    // Mid-frame asynchronous reset during bit 4 of 8'hFF.
    m_if.din        = 8'hFF;
    m_if.load_valid = 1'b1;
    step();
    m_if.load_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("mid_pre_sdata",  16'(m_if.sdata), 16'h1);
    chk("mid_pre_sframe", 16'(m_if.sframe), 16'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_sdata",  16'(m_if.sdata), 16'h0);
    chk("mid_rst_sframe", 16'(m_if.sframe), 16'h0);
    chk("mid_rst_done",   16'(m_if.done), 16'h0);
    step();
    chk("mid_rst_no_done", 16'(m_if.done), 16'h0);
    rst = 1'b0;
    step();
    chk("mid_after_done", 16'(m_if.done), 16'h0);
    frame_msb(8'h81, 8'h00, 1'b0, "post_abort");
    step();

`ifdef SERIAL_TX_PARITY_EN
    frame_msb(8'h07, 8'h00, 1'b0, "par07");
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
